img_ddr_writer: RTL and testbench
=================================

IMG_DDR_WRITER -- requirements
Module: img_ddr_writer

Interface
REQ-001 Parameter IMG_INDEX, default 8'd1: ioctl_index value whose download this block captures.
REQ-002 Parameter BASE_WORD, default 29'd0: DDR 64-bit word address of image byte 0.
REQ-003 clk_sys  in  1  sole clock; also drives DDRAM_CLK externally.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 ioctl_download  in  1  HPS download active.
REQ-006 ioctl_index  in  8  download file index.
REQ-007 ioctl_wr  in  1  one-cycle byte strobe.
REQ-008 ioctl_addr  in  27  byte address within file.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 ioctl_wait  out  1  backpressure to HPS; high = no further ioctl_wr allowed.
REQ-011 DDRAM_BUSY  in  1  DDR waitrequest.
REQ-012 DDRAM_BURSTCNT  out  8  constant 8'd1.
REQ-013 DDRAM_ADDR  out  29  word address.
REQ-014 DDRAM_DIN  out  64  write data.
REQ-015 DDRAM_BE  out  8  byte enables.
REQ-016 DDRAM_WE  out  1  write request.
REQ-017 DDRAM_RD  out  1  constant 0.
REQ-018 img_loaded  out  1  image fully written to DDR.
REQ-019 byte_count  out  27  bytes accepted in current/last download.
REQ-020 overrun  out  1  sticky: ioctl_wr received while ioctl_wait high.

Function
REQ-021 Active download = ioctl_download && ioctl_index==IMG_INDEX; ioctl_wr outside active download ignored.
REQ-022 States: IDLE, FILL, WRITE, FINAL; one-hot or encoded, implementer's choice.
REQ-023 Accepted byte: lane = ioctl_addr[2:0]; stored in DIN[8*lane+7 : 8*lane]; BE[lane] set; little-endian lane order.
REQ-024 Word address of a byte = BASE_WORD + ioctl_addr[26:3], modulo 2^29 (wrap, no error).
REQ-025 IDLE/FILL, accepted byte with lane 7 -> WRITE next cycle, with that byte included.
REQ-026 FILL, accepted byte whose word address differs from held word -> held word written first (WRITE), byte parked in one-entry pending register, merged into a cleared word after write completes.
REQ-027 ioctl_wait rises the cycle after any byte that causes WRITE; falls the cycle after the write is accepted; low at all other times.
REQ-028 WRITE: DDRAM_WE=1 with ADDR/DIN/BE stable; write accepted on the rising edge where DDRAM_WE=1 and DDRAM_BUSY=0; DDRAM_WE=0 the following cycle.
REQ-029 After acceptance: BE and DIN cleared to 0, state FILL (or IDLE if download ended).
REQ-030 Falling edge of active download with BE!=0 -> FINAL: partial word written via WRITE rules; img_loaded set the cycle after acceptance.
REQ-031 Falling edge of active download with BE==0 -> img_loaded set next cycle.
REQ-032 Rising edge of active download -> img_loaded=0, byte_count=0, overrun=0, BE=0, pending cleared.
REQ-033 byte_count increments by 1 per accepted byte, saturates at 2^27-1.
REQ-034 ioctl_wr while ioctl_wait=1 -> byte dropped, overrun=1, byte_count unchanged.
REQ-035 ioctl_wr and download falling edge in same cycle -> byte accepted, then FINAL.
REQ-036 Write latency: lane-7 byte on cycle N -> DDRAM_WE=1 on cycle N+1 (minimum).

Reset
REQ-037 reset_n=0, asynchronously: state IDLE, DDRAM_WE=0, ioctl_wait=0, DDRAM_ADDR=0, DDRAM_DIN=0, DDRAM_BE=0, img_loaded=0, byte_count=0, overrun=0, pending empty.
REQ-038 Reset mid-WRITE abandons the write; no retry after release.

Verification
REQ-039 Bytes 0x01..0x08 at addr 0..7, BUSY=0 -> one write, ADDR=BASE_WORD, DIN=64'h0807060504030201, BE=8'hFF, ioctl_wait high exactly 2 cycles.
REQ-040 Same, BUSY held 5 cycles -> DDRAM_WE held 6 cycles, ioctl_wait released the cycle after BUSY falls.
REQ-041 3 bytes 0xAA,0xBB,0xCC at addr 0..2 then download falls -> write DIN=64'h0000000000CCBBAA, BE=8'h07; img_loaded=1; byte_count=3.
REQ-042 Bytes at addr 0 then addr 16 -> write ADDR=BASE_WORD, BE=8'h01; then held word ADDR=BASE_WORD+2, BE=8'h01.
REQ-043 ioctl_wr asserted while ioctl_wait=1 -> overrun=1, byte not in DIN; next download start clears overrun.
REQ-044 reset_n low during WRITE with BUSY=1 -> DDRAM_WE and ioctl_wait 0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/img_ddr_writer.sv
// img_ddr_writer: packs HPS ioctl download bytes into 64-bit DDR words and writes them out
module img_ddr_writer #(
  parameter logic [7:0]  IMG_INDEX = 8'd1,
  parameter logic [28:0] BASE_WORD = 29'd0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE,
  output logic        DDRAM_RD,
  output logic        img_loaded,
  output logic [26:0] byte_count,
  output logic        overrun
);
  typedef enum logic [1:0] {IDLE, FILL, WRITE, FINAL} state_t;
  state_t      state, st_cur;
  logic        active, active_d, rise, fall, win, acc, miss, fin, ending;
  logic [2:0]  lane, pend_lane;
  logic [28:0] waddr, pend_addr;
  logic [7:0]  be_cur, be_m, pend_data;
  logic [63:0] din_cur, din_m;
  logic        pend_v;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_RD       = 1'b0;
  assign active  = ioctl_download && ioctl_index == IMG_INDEX;
  assign rise    = active && !active_d;
  assign fall    = !active && active_d;
  // the cycle the download drops still accepts a byte so it lands in the final word
  assign win     = active || active_d;
  assign acc     = ioctl_wr && win && !ioctl_wait;
  assign lane    = ioctl_addr[2:0];
  assign waddr   = BASE_WORD + 29'(ioctl_addr[26:3]);
  assign st_cur  = rise ? IDLE : state;
  assign be_cur  = rise ? 8'd0 : DDRAM_BE;
  assign din_cur = rise ? 64'd0 : DDRAM_DIN;
  assign be_m    = be_cur | (8'd1 << lane);
  assign din_m   = (din_cur & ~(64'hFF << {lane, 3'b000})) | (64'(ioctl_dout) << {lane, 3'b000});
  assign miss    = acc && be_cur != 8'd0 && waddr != DDRAM_ADDR;
  assign fin     = ending || fall;
  // byte capture, word assembly and DDR write handshake
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      active_d   <= 1'b0;
      DDRAM_ADDR <= '0;
      DDRAM_DIN  <= '0;
      DDRAM_BE   <= '0;
      DDRAM_WE   <= 1'b0;
      ioctl_wait <= 1'b0;
      img_loaded <= 1'b0;
      byte_count <= '0;
      overrun    <= 1'b0;
      pend_v     <= 1'b0;
      pend_lane  <= '0;
      pend_addr  <= '0;
      pend_data  <= '0;
      ending     <= 1'b0;
    end else begin
      active_d <= active;
      overrun  <= (overrun && !rise) || (ioctl_wr && win && ioctl_wait);
      if (acc) byte_count <= rise ? 27'd1 : (&byte_count ? byte_count : byte_count + 27'd1);
      else if (rise) byte_count <= '0;
      if (rise) begin
        img_loaded <= 1'b0;
        ending     <= 1'b0;
        pend_v     <= 1'b0;
        DDRAM_BE   <= '0;
        DDRAM_DIN  <= '0;
        DDRAM_WE   <= 1'b0;
        ioctl_wait <= 1'b0;
        state      <= IDLE;
      end
      if (st_cur == WRITE || st_cur == FINAL) begin
        if (fall) ending <= 1'b1;
        if (st_cur == FINAL) ioctl_wait <= 1'b0;
        if (!DDRAM_BUSY) begin
          DDRAM_WE  <= 1'b0;
          DDRAM_BE  <= '0;
          DDRAM_DIN <= '0;
          if (st_cur == FINAL) begin
            img_loaded <= 1'b1;
            state      <= IDLE;
          end else if (pend_v) begin
            DDRAM_ADDR <= pend_addr;
            DDRAM_BE   <= 8'd1 << pend_lane;
            DDRAM_DIN  <= 64'(pend_data) << {pend_lane, 3'b000};
            pend_v     <= 1'b0;
            DDRAM_WE   <= fin || pend_lane == 3'd7;
            state      <= fin ? FINAL : (pend_lane == 3'd7 ? WRITE : FILL);
          end else if (fin) begin
            img_loaded <= 1'b1;
            state      <= IDLE;
          end else state <= FILL;
        end
      end else begin
        ioctl_wait <= 1'b0;
        if (miss) begin
          pend_v     <= 1'b1;
          pend_lane  <= lane;
          pend_addr  <= waddr;
          pend_data  <= ioctl_dout;
          ending     <= fall;
          DDRAM_WE   <= 1'b1;
          ioctl_wait <= 1'b1;
          state      <= WRITE;
        end else if (acc) begin
          DDRAM_ADDR <= waddr;
          DDRAM_BE   <= be_m;
          DDRAM_DIN  <= din_m;
          ending     <= fall;
          DDRAM_WE   <= lane == 3'd7 || fall;
          ioctl_wait <= lane == 3'd7;
          state      <= lane == 3'd7 ? WRITE : (fall ? FINAL : FILL);
        end else if (fall) begin
          DDRAM_WE   <= be_cur != 8'd0;
          img_loaded <= be_cur == 8'd0;
          state      <= be_cur != 8'd0 ? FINAL : IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_img_ddr_writer.sv
// tb_img_ddr_writer: directed checks of byte packing, DDR handshake, end-of-download and reset
module tb_img_ddr_writer;
  localparam logic [28:0] BASE = 29'h1FFF_FFFF;
  logic        clk_sys = 1'b0, reset_n = 1'b0;
  logic        ioctl_download = 1'b0, ioctl_wr = 1'b0, DDRAM_BUSY = 1'b0;
  logic [7:0]  ioctl_index = 8'd1, ioctl_dout = 8'd0;
  logic [26:0] ioctl_addr = '0;
  logic        ioctl_wait, DDRAM_WE, DDRAM_RD, img_loaded, overrun;
  logic [7:0]  DDRAM_BURSTCNT, DDRAM_BE;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [26:0] byte_count;
  int checks = 0, errors = 0;

  img_ddr_writer #(.IMG_INDEX(8'd1), .BASE_WORD(BASE)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .DDRAM_BUSY(DDRAM_BUSY),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DIN(DDRAM_DIN),
    .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE), .DDRAM_RD(DDRAM_RD),
    .img_loaded(img_loaded), .byte_count(byte_count), .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [26:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_we", DDRAM_WE, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_addr", DDRAM_ADDR, 0);
    chk("rst_din", DDRAM_DIN, 0);
    chk("rst_be", DDRAM_BE, 0);
    chk("rst_loaded", img_loaded, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("burstcnt", DDRAM_BURSTCNT, 1);
    chk("rd", DDRAM_RD, 0);
    reset_n = 1'b1;
    tick();
    // full word, no backpressure
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) put(27'(i), 8'(i + 1));
    chk("w1_we", DDRAM_WE, 1);
    chk("w1_wait_a", ioctl_wait, 1);
    chk("w1_addr", DDRAM_ADDR, 64'(BASE));
    chk("w1_din", DDRAM_DIN, 64'h0807060504030201);
    chk("w1_be", DDRAM_BE, 8'hFF);
    tick();
    chk("w1_we_off", DDRAM_WE, 0);
    chk("w1_wait_b", ioctl_wait, 1);
    chk("w1_be_clr", DDRAM_BE, 0);
    tick();
    chk("w1_wait_off", ioctl_wait, 0);
    chk("w1_count", byte_count, 8);
    // full word with BUSY held 5 cycles; address wraps to 0
    for (int i = 8; i < 16; i++) put(27'(i), 8'(i + 9));
    DDRAM_BUSY = 1'b1;
    chk("w2_addr", DDRAM_ADDR, 0);
    chk("w2_din", DDRAM_DIN, 64'h1817161514131211);
    for (int i = 0; i < 5; i++) begin
      chk("w2_we_busy", DDRAM_WE, 1);
      tick();
    end
    DDRAM_BUSY = 1'b0;
    chk("w2_we_6th", DDRAM_WE, 1);
    chk("w2_wait_6th", ioctl_wait, 1);
    tick();
    chk("w2_we_off", DDRAM_WE, 0);
    chk("w2_wait_7th", ioctl_wait, 1);
    tick();
    chk("w2_wait_off", ioctl_wait, 0);
    // download ends on an empty word
    ioctl_download = 1'b0;
    tick();
    chk("end_empty_loaded", img_loaded, 1);
    chk("end_empty_we", DDRAM_WE, 0);
    chk("end_empty_count", byte_count, 16);
    // partial word flushed at download end
    ioctl_download = 1'b1;
    tick();
    chk("start_loaded", img_loaded, 0);
    chk("start_count", byte_count, 0);
    put(27'd0, 8'hAA);
    put(27'd1, 8'hBB);
    put(27'd2, 8'hCC);
    ioctl_download = 1'b0;
    tick();
    chk("fin_we", DDRAM_WE, 1);
    chk("fin_addr", DDRAM_ADDR, 64'(BASE));
    chk("fin_din", DDRAM_DIN, 64'h0000000000CCBBAA);
    chk("fin_be", DDRAM_BE, 8'h07);
    chk("fin_loaded_early", img_loaded, 0);
    tick();
    chk("fin_loaded", img_loaded, 1);
    chk("fin_we_off", DDRAM_WE, 0);
    chk("fin_count", byte_count, 3);
    // byte arriving in the same cycle the download drops
    ioctl_download = 1'b1;
    tick();
    put(27'd0, 8'h31);
    put(27'd1, 8'h32);
    ioctl_download = 1'b0;
    put(27'd2, 8'h33);
    chk("edge_we", DDRAM_WE, 1);
    chk("edge_din", DDRAM_DIN, 64'h0000000000333231);
    chk("edge_be", DDRAM_BE, 8'h07);
    chk("edge_count", byte_count, 3);
    tick();
    chk("edge_loaded", img_loaded, 1);
    // address jump forces write of held word, new byte parked
    ioctl_download = 1'b1;
    tick();
    put(27'd0, 8'h5A);
    chk("jump_no_we", DDRAM_WE, 0);
    put(27'd16, 8'h6B);
    chk("jump_we", DDRAM_WE, 1);
    chk("jump_addr", DDRAM_ADDR, 64'(BASE));
    chk("jump_be", DDRAM_BE, 8'h01);
    chk("jump_din", DDRAM_DIN, 64'h5A);
    tick();
    chk("jump_we_off", DDRAM_WE, 0);
    chk("held_addr", DDRAM_ADDR, 64'(29'd1));
    chk("held_be", DDRAM_BE, 8'h01);
    chk("held_din", DDRAM_DIN, 64'h6B);
    tick();
    chk("held_wait_off", ioctl_wait, 0);
    // byte offered while ioctl_wait is high is dropped
    put(27'd23, 8'h99);
    chk("ovr_din", DDRAM_DIN, 64'h990000000000006B);
    chk("ovr_be", DDRAM_BE, 8'h81);
    chk("ovr_wait", ioctl_wait, 1);
    put(27'd24, 8'hEE);
    chk("ovr_flag", overrun, 1);
    chk("ovr_din_clr", DDRAM_DIN, 0);
    chk("ovr_be_clr", DDRAM_BE, 0);
    chk("ovr_count", byte_count, 3);
    tick();
    ioctl_download = 1'b0;
    tick();
    chk("ovr_sticky", overrun, 1);
    ioctl_download = 1'b1;
    tick();
    chk("ovr_cleared", overrun, 0);
    // reset during a stalled write
    DDRAM_BUSY = 1'b1;
    for (int i = 0; i < 8; i++) put(27'(i), 8'(i));
    chk("rw_we", DDRAM_WE, 1);
    put(27'd8, 8'h55);
    chk("rw_ovr", overrun, 1);
    reset_n = 1'b0;
    #1;
    chk("rw_we_0", DDRAM_WE, 0);
    chk("rw_wait_0", ioctl_wait, 0);
    chk("rw_addr_0", DDRAM_ADDR, 0);
    chk("rw_din_0", DDRAM_DIN, 0);
    chk("rw_be_0", DDRAM_BE, 0);
    chk("rw_count_0", byte_count, 0);
    chk("rw_ovr_0", overrun, 0);
    ioctl_download = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("rw_no_retry", DDRAM_WE, 0);
    // other file index is ignored
    DDRAM_BUSY = 1'b0;
    ioctl_index = 8'd2;
    ioctl_download = 1'b1;
    tick();
    put(27'd7, 8'h42);
    chk("idx_we", DDRAM_WE, 0);
    chk("idx_count", byte_count, 0);
    chk("idx_be", DDRAM_BE, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
